// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
// The state encodings match the entry count, so a stage can report its occupancy directly.
package pipe_pkg;

    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] pipe_state_t;

    localparam pipe_state_t ST_EMPTY = 2'd0;
    localparam pipe_state_t ST_ONE   = 2'd1;
    localparam pipe_state_t ST_TWO   = 2'd2;

    function automatic logic [1:0] occupancy_of(input pipe_state_t st);
        return st;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register with a load enable.
// Reset and clear both return it to the BUBBLE value.
module pipe_slot #(
    parameter int unsigned        DATA_W = 32,
    parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_d, data_q;

    // Clear wins over load.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = BUBBLE;
        end else if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= BUBBLE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush.
// SKID=1 gives two entries and a registered IN_READY; SKID=0 gives one entry and a combinational IN_READY.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W = 32,
    parameter logic [DATA_W-1:0]  BUBBLE = '0,
    parameter int unsigned        SKID   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY
);

    pipe_state_t       state_d, state_q;
    logic              in_ready_d, in_ready_q;
    logic              in_fire, out_fire;
    logic              main_load, main_clr, skid_load, skid_clr;
    logic [DATA_W-1:0] main_din, main_q, skid_q;

    assign OUT_VALID = (state_q != ST_EMPTY);
    assign out_fire  = OUT_VALID && OUT_READY;
    assign IN_READY  = (SKID != 0) ? in_ready_q : (!OUT_VALID || OUT_READY);
    assign in_fire   = IN_VALID && IN_READY;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_din  = IN_DATA;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (FLUSH) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    // With SKID=0 an input fire here always coincides with an output fire.
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                        main_din  = skid_q;
                        skid_clr  = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign in_ready_d = (state_d != ST_TWO);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .clr_i  (main_clr),
        .load_i (main_load),
        .d_i    (main_din),
        .q_o    (main_q)
    );

    pipe_slot #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE)
    ) u_skid (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .clr_i  (skid_clr),
        .load_i (skid_load),
        .d_i    (IN_DATA),
        .q_o    (skid_q)
    );

    assign OUT_DATA  = main_q;
    assign OCCUPANCY = occupancy_of(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance, each checked against a bounded-queue model.
module tb_pipe_stage_reg;

    localparam logic [31:0] BUBBLE = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        iv1 = 1'b0, ord1 = 1'b1, ird1, ov1;
    logic        iv0 = 1'b0, ord0 = 1'b1, ird0, ov0;
    logic [31:0] d1 = '0, d0 = '0, od1, od0;
    logic [1:0]  occ1, occ0;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [31:0] q1[$];
    logic [31:0] q0[$];
    bit          p1 = 1'b0, p0 = 1'b0;
    logic [31:0] pd1 = '0, pd0 = '0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .BUBBLE(BUBBLE), .SKID(1)) u_dut1 (
        .CLK(clk), .RESET(rst), .FLUSH(flush),
        .IN_VALID(iv1), .IN_READY(ird1), .IN_DATA(d1),
        .OUT_VALID(ov1), .OUT_READY(ord1), .OUT_DATA(od1), .OCCUPANCY(occ1)
    );

    pipe_stage_reg #(.DATA_W(32), .BUBBLE(BUBBLE), .SKID(0)) u_dut0 (
        .CLK(clk), .RESET(rst), .FLUSH(flush),
        .IN_VALID(iv0), .IN_READY(ird0), .IN_DATA(d0),
        .OUT_VALID(ov0), .OUT_READY(ord0), .OUT_DATA(od0), .OCCUPANCY(occ0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: the model's queue holds exactly the entries the stage should hold.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("occ_skid1",      32'(occ1), 32'(q1.size()));
                chk("out_valid_skid1", 32'(ov1),  32'(q1.size() != 0));
                chk("out_data_skid1",  od1, (q1.size() != 0) ? q1[0] : BUBBLE);
                chk("in_ready_skid1",  32'(ird1), 32'(q1.size() < 2));
                chk("occ_skid0",      32'(occ0), 32'(q0.size()));
                chk("out_valid_skid0", 32'(ov0),  32'(q0.size() != 0));
                chk("out_data_skid0",  od0, (q0.size() != 0) ? q0[0] : BUBBLE);
                chk("in_ready_skid0",  32'(ird0), 32'((q0.size() == 0) || ord0));
                if (ov1 && ord1 && q1.size() != 0) void'(q1.pop_front());
                if (ov0 && ord0 && q0.size() != 0) void'(q0.pop_front());
            end
            if (rst || flush) begin
                q1.delete();
                q0.delete();
            end
            if (rst) mon_en = 1'b1;
        end
    end

    // One cycle of stimulus; accepted inputs enter the model at the edge that loads them.
    task automatic cyc(input logic r, input logic f,
                       input logic v1, input logic [31:0] a1, input logic o1,
                       input logic v0, input logic [31:0] a0, input logic o0);
        @(posedge clk);
        if (p1) q1.push_back(pd1);
        if (p0) q0.push_back(pd0);
        #1;
        rst = r; flush = f;
        iv1 = v1; d1 = a1; ord1 = o1;
        iv0 = v0; d0 = a0; ord0 = o0;
        @(negedge clk);
        p1  = v1 && ird1 && !f && !r;
        pd1 = a1;
        p0  = v0 && ird0 && !f && !r;
        pd0 = a0;
    endtask

    task automatic idle1(input logic o1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, o1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic send1(input logic [31:0] a, input logic o1);
        cyc(1'b0, 1'b0, 1'b1, a, o1, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin : driver
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        idle1(1'b1);
        idle1(1'b1);

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++) send1(32'(i), 1'b1);
        idle1(1'b1);
        idle1(1'b1);

        // Stall fills both entries, then drain in order.
        send1(32'hA, 1'b0);
        send1(32'hB, 1'b0);
        send1(32'hC, 1'b0);
        send1(32'hC, 1'b1);
        send1(32'hC, 1'b1);
        idle1(1'b1);
        idle1(1'b1);
        idle1(1'b1);

        // Flush from TWO with a live input.
        send1(32'h11, 1'b0);
        send1(32'h22, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h9, 1'b0, 1'b0, 32'h0, 1'b1);
        idle1(1'b1);
        idle1(1'b1);

        // Reset and flush together while holding one entry.
        send1(32'h33, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 1'b1);
        idle1(1'b0);
        idle1(1'b1);

        // Single-entry stage: stall, then replace in one cycle.
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h55, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h66, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h66, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h77, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

        // Random traffic on both stages.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 1) == 1));
        end

        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
